// File: rtl/prq_access_arbiter.sv
// Posted-receive-queue CAM access arbiter: round-robin between processor inserts and network finds.
// Optional PRQ_ARB_STATS_EN adds saturating resolution counters (stat_*).
module prq_access_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned MAX_ENTRIES    = 2**ADDR_WIDTH - 2,
  parameter int unsigned TIMEOUT_CYCLES = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ins_valid,
  output logic                      ins_ready,
  input  logic [31:0]               ins_request,
  input  logic [31:0]               ins_data_ptr,
  output logic                      ins_done,
  output logic [1:0]                ins_status,
  input  logic                      find_valid,
  output logic                      find_ready,
  input  logic [ADDR_WIDTH-1:0]     find_key,
  output logic                      res_valid,
  output logic                      res_hit,
  output logic [31:0]               res_ptr,
  output logic                      res_timeout,
  output logic                      cam_insert,
  output logic                      cam_find,
  output logic [31:0]               cam_request,
  output logic [31:0]               cam_data_ptr,
  output logic [ADDR_WIDTH-1:0]     cam_message,
  input  logic                      cam_found,
  input  logic                      cam_not_found,
  input  logic [31:0]               cam_posted_request,
  input  logic [2**ADDR_WIDTH-1:0]  cam_mbits,
  output logic [ADDR_WIDTH:0]       occupancy,
  output logic                      err_sticky
`ifdef PRQ_ARB_STATS_EN
  ,
  output logic [31:0]               stat_hits,
  output logic [31:0]               stat_misses,
  output logic [31:0]               stat_dups,
  output logic [31:0]               stat_fulls,
  output logic [31:0]               stat_timeouts
`endif
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    INS_SETTLE = 2'd1,
    FIND_WAIT  = 2'd2
  } state_t;

  localparam int unsigned         WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]     WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0]     WD_ONE  = WD_W'(1);
  localparam logic [ADDR_WIDTH:0] MAX_OCC = (ADDR_WIDTH + 1)'(MAX_ENTRIES);
  localparam logic [ADDR_WIDTH:0] OCC_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [1:0]          ST_OK   = 2'b00;
  localparam logic [1:0]          ST_DUP  = 2'b01;
  localparam logic [1:0]          ST_FULL = 2'b10;

  state_t          state, state_next;
  logic            rr_ins;
  logic            grant_ins, grant_find;
  logic            key_dup, at_cap, ins_accept;
  logic            cam_resp, wd_expire;
  logic [WD_W-1:0] wd;
  logic            ev_hit, ev_miss, ev_dup, ev_full;

  assign key_dup    = cam_mbits[ins_request[ADDR_WIDTH-1:0]];
  assign at_cap     = (occupancy >= MAX_OCC);
  assign cam_resp   = cam_found | cam_not_found;
  assign ins_accept = grant_ins & ~key_dup & ~at_cap;
  assign ev_dup     = grant_ins & key_dup;
  assign ev_full    = grant_ins & ~key_dup & at_cap;
  assign ev_hit     = (state == FIND_WAIT) & cam_found;
  assign ev_miss    = (state == FIND_WAIT) & ~cam_found & cam_not_found;
  assign wd_expire  = (state == FIND_WAIT) & ~cam_resp & (wd == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // INS_SETTLE covers the cam_insert cycle plus one more, so the next duplicate
  // check in IDLE always sees the freshly written mbit.
  always_comb begin
    state_next = state;
    grant_ins  = 1'b0;
    grant_find = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n) begin
          if (ins_valid && (!find_valid || rr_ins)) grant_ins  = 1'b1;
          else if (find_valid)                      grant_find = 1'b1;
        end
        if (grant_find)                            state_next = FIND_WAIT;
        else if (grant_ins && !key_dup && !at_cap) state_next = INS_SETTLE;
      end
      INS_SETTLE: if (!cam_insert)             state_next = IDLE;
      FIND_WAIT:  if (cam_resp || wd_expire)   state_next = IDLE;
      default:                                 state_next = IDLE;
    endcase
    ins_ready  = grant_ins;
    find_ready = grant_find;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ins       <= 1'b1;
      ins_done     <= 1'b0;
      ins_status   <= '0;
      res_valid    <= 1'b0;
      res_hit      <= 1'b0;
      res_ptr      <= '0;
      res_timeout  <= 1'b0;
      cam_insert   <= 1'b0;
      cam_find     <= 1'b0;
      cam_request  <= '0;
      cam_data_ptr <= '0;
      cam_message  <= '0;
      wd           <= '0;
      occupancy    <= '0;
      err_sticky   <= 1'b0;
    end else begin
      ins_done    <= 1'b0;
      ins_status  <= '0;
      res_valid   <= 1'b0;
      res_hit     <= 1'b0;
      res_ptr     <= '0;
      res_timeout <= 1'b0;
      cam_insert  <= 1'b0;
      cam_find    <= 1'b0;

      if (grant_ins)  rr_ins <= 1'b0;
      if (grant_find) rr_ins <= 1'b1;

      if (grant_ins) begin
        ins_done <= 1'b1;
        if (key_dup)     ins_status <= ST_DUP;
        else if (at_cap) ins_status <= ST_FULL;
        else begin
          ins_status   <= ST_OK;
          cam_insert   <= 1'b1;
          cam_request  <= ins_request;
          cam_data_ptr <= ins_data_ptr;
        end
      end

      if (grant_find) begin
        cam_find    <= 1'b1;
        cam_message <= find_key;
        wd          <= '0;
      end

      if (state == FIND_WAIT) begin
        if (cam_found) begin
          res_valid <= 1'b1;
          res_hit   <= 1'b1;
          res_ptr   <= cam_posted_request;
        end else if (cam_not_found) begin
          res_valid <= 1'b1;
        end else if (wd_expire) begin
          res_valid   <= 1'b1;
          res_timeout <= 1'b1;
        end else begin
          wd <= wd + WD_ONE;
        end
      end

      if (ins_accept)                      occupancy <= occupancy + OCC_ONE;
      else if (ev_hit && occupancy != '0)  occupancy <= occupancy - OCC_ONE;

      if ((state != FIND_WAIT && cam_resp) || wd_expire || (ev_hit && occupancy == '0))
        err_sticky <= 1'b1;
    end
  end

`ifdef PRQ_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits     <= '0;
      stat_misses   <= '0;
      stat_dups     <= '0;
      stat_fulls    <= '0;
      stat_timeouts <= '0;
    end else begin
      if (ev_hit    && stat_hits     != '1) stat_hits     <= stat_hits + 32'd1;
      if (ev_miss   && stat_misses   != '1) stat_misses   <= stat_misses + 32'd1;
      if (ev_dup    && stat_dups     != '1) stat_dups     <= stat_dups + 32'd1;
      if (ev_full   && stat_fulls    != '1) stat_fulls    <= stat_fulls + 32'd1;
      if (wd_expire && stat_timeouts != '1) stat_timeouts <= stat_timeouts + 32'd1;
    end
  end
`endif

endmodule
